// File: rtl/axis_frame_tag_strip.sv
// Strips TAG_WORD leading words from each AXI4-Stream frame, presents the tag as a per-frame sideband and reports per-frame status.
// One cycle input-to-output latency through an output register plus skid entry; s_axis_tready is registered and the final header word waits for the output stage to drain.
module axis_frame_tag_strip #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_ENABLE = 1,
    parameter int TAG_WIDTH  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [TAG_WIDTH-1:0]  m_axis_tag,
    output logic                  stat_valid,
    output logic [LEN_WIDTH-1:0]  stat_len,
    output logic                  stat_user,
    output logic                  stat_short,
    output logic                  busy
);
    localparam int TAG_WORDS = (TAG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int TAG_PAD   = TAG_WORDS * DATA_WIDTH;
    localparam int PTR_W     = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_WORDS - 1);
    localparam bit   HAS_TAG  = (TAG_ENABLE != 0);

    typedef enum logic {S_HEADER, S_PAYLOAD} state_t;
    localparam state_t S_IDLE = HAS_TAG ? S_HEADER : S_PAYLOAD;

    state_t                r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [TAG_PAD-1:0]    r_tag_acc;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_s_rdy;
    logic                  r_busy;
    logic                  r_in_frame;
    logic                  r_out_vld;
    logic                  r_out_last;
    logic                  r_out_user;
    logic [DATA_WIDTH-1:0] r_out_dat;
    logic                  r_skid_vld;
    logic                  r_skid_last;
    logic                  r_skid_user;
    logic [DATA_WIDTH-1:0] r_skid_dat;
    logic                  r_stat_vld;
    logic                  r_stat_user;
    logic                  r_stat_short;
    logic [LEN_WIDTH-1:0]  r_stat_len;

    logic                  w_acc;
    logic                  w_hdr_acc;
    logic                  w_pld_acc;
    logic                  w_hdr_done;
    logic                  w_in_user;
    logic                  w_out_load;
    logic                  w_out_vld_nxt;
    logic                  w_skid_vld_nxt;
    logic                  w_in_frame_nxt;
    logic                  w_rdy_nxt;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [LEN_WIDTH-1:0]  w_cnt_inc;
    logic [TAG_PAD-1:0]    w_tag_full;

    assign w_acc          = s_axis_tvalid && r_s_rdy;
    assign w_hdr_acc      = w_acc && (r_state == S_HEADER);
    assign w_pld_acc      = w_acc && (r_state == S_PAYLOAD);
    assign w_hdr_done     = w_hdr_acc && (r_ptr == PTR_LAST) && !s_axis_tlast;
    assign w_in_user      = s_axis_tlast && s_axis_tuser;
    assign w_cnt_inc      = (&r_cnt) ? r_cnt : r_cnt + LEN_WIDTH'(1);
    assign w_out_load     = !r_out_vld || m_axis_tready;
    assign w_out_vld_nxt  = w_out_load ? (r_skid_vld || w_pld_acc) : 1'b1;
    assign w_skid_vld_nxt = !w_out_load && (r_skid_vld || w_pld_acc);
    assign w_in_frame_nxt = w_pld_acc ? !s_axis_tlast : r_in_frame;

    always_comb begin
        w_tag_full = r_tag_acc;
        w_tag_full[r_ptr*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
    end

    if (TAG_PAD > TAG_WIDTH) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^w_tag_full[TAG_PAD-1:TAG_WIDTH];
    end

    // Ready is computed one cycle ahead: the final header word is only taken once
    // the output stage is empty, so m_axis_tag never changes under a held beat.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rdy_nxt   = 1'b1;
        if (w_hdr_acc) begin
            w_ptr_nxt = (s_axis_tlast || r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
            if (w_hdr_done) w_state_nxt = S_PAYLOAD;
        end
        if (w_pld_acc && s_axis_tlast) w_state_nxt = S_IDLE;
        if (w_state_nxt == S_PAYLOAD)
            w_rdy_nxt = !w_skid_vld_nxt;
        else if (w_ptr_nxt == PTR_LAST)
            w_rdy_nxt = !w_out_vld_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_tag_acc    <= '0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_s_rdy      <= 1'b0;
            r_busy       <= 1'b0;
            r_in_frame   <= 1'b0;
            r_out_vld    <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_user   <= 1'b0;
            r_out_dat    <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_user  <= 1'b0;
            r_skid_dat   <= '0;
            r_stat_vld   <= 1'b0;
            r_stat_user  <= 1'b0;
            r_stat_short <= 1'b0;
            r_stat_len   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_s_rdy    <= w_rdy_nxt;
            r_in_frame <= w_in_frame_nxt;
            r_busy     <= HAS_TAG ? (w_state_nxt != S_HEADER || w_ptr_nxt != '0) : w_in_frame_nxt;
            r_stat_vld <= 1'b0;

            if (w_hdr_acc) r_tag_acc <= w_tag_full;
            if (w_hdr_done) begin
                r_tag <= w_tag_full[TAG_WIDTH-1:0];
                r_cnt <= '0;
            end
            if (w_hdr_acc && s_axis_tlast) begin
                r_stat_vld   <= 1'b1;
                r_stat_short <= 1'b1;
                r_stat_len   <= '0;
                r_stat_user  <= s_axis_tuser;
            end
            if (w_pld_acc) begin
                r_cnt <= s_axis_tlast ? '0 : w_cnt_inc;
                if (s_axis_tlast) begin
                    r_stat_vld   <= 1'b1;
                    r_stat_short <= 1'b0;
                    r_stat_len   <= w_cnt_inc;
                    r_stat_user  <= s_axis_tuser;
                end
            end

            // Skid is only ever filled while the output register is stalled.
            if (w_out_load) begin
                r_out_vld  <= r_skid_vld || w_pld_acc;
                r_skid_vld <= 1'b0;
                if (r_skid_vld) begin
                    r_out_dat  <= r_skid_dat;
                    r_out_last <= r_skid_last;
                    r_out_user <= r_skid_user;
                end else if (w_pld_acc) begin
                    r_out_dat  <= s_axis_tdata;
                    r_out_last <= s_axis_tlast;
                    r_out_user <= w_in_user;
                end
            end else if (w_pld_acc) begin
                r_skid_vld  <= 1'b1;
                r_skid_dat  <= s_axis_tdata;
                r_skid_last <= s_axis_tlast;
                r_skid_user <= w_in_user;
            end
        end
    end

    assign s_axis_tready = r_s_rdy;
    assign m_axis_tdata  = r_out_dat;
    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;
    assign m_axis_tag    = r_tag;
    assign stat_valid    = r_stat_vld;
    assign stat_len      = r_stat_len;
    assign stat_user     = r_stat_user;
    assign stat_short    = r_stat_short;
    assign busy          = r_busy;
endmodule

// File: tb/tb_axis_frame_tag_strip.sv
// Bench for axis_frame_tag_strip: frame-level reference model, default instance plus a LEN_WIDTH=4 twin in lockstep
// and a TAG_ENABLE=0 instance with its own stimulus.
module tb_axis_frame_tag_strip;
    logic clk;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tuser, m_tready;
    logic [7:0] c_s_dat;
    logic       c_s_vld, c_s_last, c_s_user;

    logic        a_s_rdy, a_m_vld, a_m_last, a_m_user, a_st_vld, a_st_user, a_st_short, a_busy;
    logic [7:0]  a_m_dat;
    logic [15:0] a_m_tag, a_st_len;

    logic        b_st_vld;
    logic [3:0]  b_st_len;
    logic        unused_b_s_rdy, unused_b_m_vld, unused_b_m_last, unused_b_m_user;
    logic        unused_b_st_user, unused_b_st_short, unused_b_busy;
    logic [7:0]  unused_b_m_dat;
    logic [15:0] unused_b_m_tag;

    logic        c_s_rdy, c_m_vld, c_m_last, c_m_user, c_st_vld, c_st_short;
    logic        unused_c_st_user, unused_c_busy;
    logic [7:0]  c_m_dat;
    logic [15:0] c_m_tag, c_st_len;

    axis_frame_tag_strip #(.DATA_WIDTH(8), .TAG_ENABLE(1), .TAG_WIDTH(16), .LEN_WIDTH(16)) u_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_s_rdy),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_m_dat), .m_axis_tvalid(a_m_vld), .m_axis_tready(m_tready),
        .m_axis_tlast(a_m_last), .m_axis_tuser(a_m_user), .m_axis_tag(a_m_tag),
        .stat_valid(a_st_vld), .stat_len(a_st_len), .stat_user(a_st_user),
        .stat_short(a_st_short), .busy(a_busy));

    axis_frame_tag_strip #(.DATA_WIDTH(8), .TAG_ENABLE(1), .TAG_WIDTH(16), .LEN_WIDTH(4)) u_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(unused_b_s_rdy),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(unused_b_m_dat), .m_axis_tvalid(unused_b_m_vld), .m_axis_tready(m_tready),
        .m_axis_tlast(unused_b_m_last), .m_axis_tuser(unused_b_m_user), .m_axis_tag(unused_b_m_tag),
        .stat_valid(b_st_vld), .stat_len(b_st_len), .stat_user(unused_b_st_user),
        .stat_short(unused_b_st_short), .busy(unused_b_busy));

    axis_frame_tag_strip #(.DATA_WIDTH(8), .TAG_ENABLE(0), .TAG_WIDTH(16), .LEN_WIDTH(16)) u_c (
        .clk(clk), .rst(rst),
        .s_axis_tdata(c_s_dat), .s_axis_tvalid(c_s_vld), .s_axis_tready(c_s_rdy),
        .s_axis_tlast(c_s_last), .s_axis_tuser(c_s_user),
        .m_axis_tdata(c_m_dat), .m_axis_tvalid(c_m_vld), .m_axis_tready(m_tready),
        .m_axis_tlast(c_m_last), .m_axis_tuser(c_m_user), .m_axis_tag(c_m_tag),
        .stat_valid(c_st_vld), .stat_len(c_st_len), .stat_user(unused_c_st_user),
        .stat_short(c_st_short), .busy(unused_c_busy));

    typedef struct packed { logic [7:0] d; logic l; logic u; logic [15:0] tag; } beat_t;
    typedef struct packed { logic [15:0] len; logic [3:0] len_b; logic u; logic sh; logic vb; } stat_t;
    typedef logic [7:0] bq_t[$];

    beat_t obs_b[$], exp_b[$];
    stat_t obs_s[$], exp_s[$];
    int    total = 0;
    int    bad = 0;
    int    waits = 0;
    bit    rand_on = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects accepted beats and status, and checks stall stability.
    logic        prev_stall;
    logic [26:0] prev_out;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {a_m_vld, a_m_dat, a_m_last, a_m_user, a_m_tag}, prev_out);
            if (a_m_vld && m_tready) obs_b.push_back({a_m_dat, a_m_last, a_m_user, a_m_tag});
            if (a_st_vld) obs_s.push_back({a_st_len, b_st_len, a_st_user, a_st_short, b_st_vld});
            prev_stall <= a_m_vld && !m_tready;
            prev_out   <= {a_m_vld, a_m_dat, a_m_last, a_m_user, a_m_tag};
        end
    end

    task automatic tick();
        logic r0, nr;
        @(posedge clk);
        #1;
        nr = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
        if (nr !== m_tready) begin
            r0 = a_s_rdy;
            m_tready = nr;
            #1;
            chk("rdy_vs_mready", a_s_rdy, r0);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
        logic acc;
        acc = 0;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1;
        for (int g = 0; g < 1000 && !acc; g++) begin
            @(negedge clk);
            acc = a_s_rdy;
            waits++;
            tick();
        end
        if (!acc) chk("s_accept_timeout", acc, 1);
    endtask

    // Reference: first two bytes form the tag (LSB first), the rest is payload.
    task automatic model_frame(input bq_t b, input logic u);
        int n;
        int plen;
        n = b.size();
        plen = n - 2;
        if (n <= 2) exp_s.push_back({16'd0, 4'd0, u, 1'b1, 1'b1});
        else begin
            for (int i = 2; i < n; i++)
                exp_b.push_back({b[i], 1'(i == n - 1), 1'((i == n - 1) && u), b[1], b[0]});
            exp_s.push_back({16'(plen), 4'(plen > 15 ? 15 : plen), u, 1'b0, 1'b1});
        end
    endtask

    task automatic send_frame(input bq_t b, input logic u);
        model_frame(b, u);
        for (int i = 0; i < b.size(); i++)
            send_beat(b[i], 1'(i == b.size() - 1), (i == b.size() - 1) ? u : 1'($urandom_range(0, 1)));
    endtask

    task automatic mk(input logic [63:0] v, input int n, output bq_t b);
        b.delete();
        for (int i = 0; i < n; i++) b.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic rand_frame(input int plen, output bq_t b);
        b.delete();
        for (int i = 0; i < plen + 2; i++) b.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drain_check();
        s_tvalid = 0; s_tlast = 0;
        for (int g = 0; g < 4000 && (obs_b.size() < exp_b.size() || obs_s.size() < exp_s.size()); g++)
            tick();
        repeat (4) tick();
        chk("beat_count", obs_b.size(), exp_b.size());
        chk("stat_count", obs_s.size(), exp_s.size());
        while (obs_b.size() > 0 && exp_b.size() > 0) chk("beat", obs_b.pop_front(), exp_b.pop_front());
        while (obs_s.size() > 0 && exp_s.size() > 0) chk("stat", obs_s.pop_front(), exp_s.pop_front());
        obs_b.delete(); exp_b.delete(); obs_s.delete(); exp_s.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_rdy"}, a_s_rdy, 0);
        chk({tag, "_m_vld"}, a_m_vld, 0);
        chk({tag, "_m_last"}, a_m_last, 0);
        chk({tag, "_m_user"}, a_m_user, 0);
        chk({tag, "_m_tag"}, a_m_tag, 0);
        chk({tag, "_st_vld"}, a_st_vld, 0);
        chk({tag, "_st_len"}, a_st_len, 0);
        chk({tag, "_st_short"}, a_st_short, 0);
        chk({tag, "_busy"}, a_busy, 0);
    endtask

    initial begin
        bq_t f;
        clk = 0; rst = 1; m_tready = 1;
        s_tdata = 0; s_tvalid = 0; s_tlast = 0; s_tuser = 0;
        c_s_dat = 0; c_s_vld = 0; c_s_last = 0; c_s_user = 0;

        // Reset state and ready after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1 rst = 0;
        tick();
        @(negedge clk);
        chk("rdy_after_reset", a_s_rdy, 1);
        tick();

        // Basic strip with latency, tag and busy checks.
        mk(64'h3412AABBCC, 5, f);
        model_frame(f, 0);
        send_beat(8'h34, 0, 0); send_beat(8'h12, 0, 0); send_beat(8'hAA, 0, 0);
        s_tvalid = 0;
        @(negedge clk);
        chk("first_lat_vld", a_m_vld, 1);
        chk("first_lat_dat", a_m_dat, 8'hAA);
        chk("tag_1234", a_m_tag, 16'h1234);
        chk("busy_mid", a_busy, 1);
        tick();
        send_beat(8'hBB, 0, 0); send_beat(8'hCC, 1, 0);
        drain_check();
        chk("busy_idle", a_busy, 0);

        // Short frames, then a normal frame.
        mk(64'h34, 1, f);       send_frame(f, 1);
        mk(64'h3412, 2, f);     send_frame(f, 0);
        mk(64'h78560102, 4, f); send_frame(f, 1);
        drain_check();

        // Back-to-back frames with tuser 0,1,0 and no input gaps.
        waits = 0;
        for (int k = 0; k < 3; k++) begin
            rand_frame(3, f);
            send_frame(f, 1'(k == 1));
        end
        chk("no_bubble", waits, 15);
        drain_check();

        // Length saturation on the LEN_WIDTH=4 twin.
        rand_frame(20, f);
        send_frame(f, 1);
        drain_check();

        // Random backpressure over 100 frames.
        rand_on = 1;
        for (int k = 0; k < 100; k++) begin
            rand_frame($urandom_range(1, 64), f);
            send_frame(f, 1'($urandom_range(0, 1)));
        end
        drain_check();
        rand_on = 0;
        tick();

        // Reset mid-payload: partial beats already out, no status, clean restart.
        rand_frame(5, f);
        f[0] = 8'h5A;
        for (int i = 0; i < 7; i++) send_beat(f[i], 0, 0);
        for (int i = 2; i < 7; i++) exp_b.push_back({f[i], 1'b0, 1'b0, f[1], f[0]});
        s_tvalid = 0;
        repeat (3) tick();
        rst = 1;
        tick();
        @(negedge clk);
        chk_reset_vals("midrst");
        tick();
        rst = 0;
        repeat (3) tick();
        drain_check();
        rand_frame(4, f);
        send_frame(f, 0);
        drain_check();

        // TAG_ENABLE=0 passthrough.
        c_s_dat = 8'hAA; c_s_vld = 1; c_s_last = 0;
        @(negedge clk);
        chk("c_rdy", c_s_rdy, 1);
        tick();
        c_s_dat = 8'hBB; c_s_last = 1;
        @(negedge clk);
        chk("c_vld0", c_m_vld, 1);
        chk("c_dat0", c_m_dat, 8'hAA);
        chk("c_last0", c_m_last, 0);
        chk("c_tag0", c_m_tag, 0);
        chk("c_rdy1", c_s_rdy, 1);
        tick();
        c_s_vld = 0; c_s_last = 0;
        @(negedge clk);
        chk("c_vld1", c_m_vld, 1);
        chk("c_dat1", c_m_dat, 8'hBB);
        chk("c_last1", c_m_last, 1);
        chk("c_user1", c_m_user, 0);
        chk("c_st_vld", c_st_vld, 1);
        chk("c_st_len", c_st_len, 2);
        chk("c_st_short", c_st_short, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
